scratchpad_mem: RTL and testbench
=================================

# scratchpad_mem

Dual-port scratchpad memory that acts as the responder on the core's instruction-fetch and data memory ports. It accepts one request per port at a time over a valid/ready handshake and returns a response after a fixed, parameterised latency. Reads honour RISC-V memory types (byte, halfword, word, signed and unsigned). It sits between the 1-stage core's `imem`/`dmem` initiators and the test harness, which loads its contents.

## Interface
- `DEPTH_WORDS`, 16384: number of 32-bit words; must be a power of two.
- `LATENCY`, 1: cycles from request acceptance to response; legal range 1..4.
- `BASE_ADDR`, 32'h0000_0000: byte address that maps to word 0.

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `imem_req_valid`  in  1  fetch request valid
- `imem_req_ready`  out  1  fetch request accepted when high together with valid
- `imem_req_addr`  in  32  fetch byte address
- `imem_resp_valid`  out  1  fetch response valid, one-cycle pulse
- `imem_resp_data`  out  32  fetched word
- `dmem_req_valid`  in  1  data request valid
- `dmem_req_ready`  out  1  data request accepted when high together with valid
- `dmem_req_addr`  in  32  data byte address
- `dmem_req_data`  in  32  store data, right-aligned
- `dmem_req_fcn`  in  1  M_XRD=0 (load), M_XWR=1 (store)
- `dmem_req_typ`  in  3  MT_B=1, MT_H=2, MT_W=3, MT_BU=5, MT_HU=6
- `dmem_resp_valid`  out  1  data response valid, one-cycle pulse
- `dmem_resp_data`  out  32  load result, extended to 32 bits; 0 for stores

## Operation
- Each port has an independent FSM with states IDLE, BUSY and RESP, and a 2-bit down-counter.
- `req_ready` is high in IDLE and RESP and low in BUSY. It is forced low while `rst` is high.
- A request is accepted on a rising edge where `req_valid && req_ready`. On that edge the port:
  - latches `typ`, `fcn` and `addr[1:0]`;
  - commits any store;
  - samples the addressed word into the response register.
- State after acceptance: RESP if `LATENCY==1`; otherwise BUSY with the counter set to `LATENCY-1`.
- In BUSY the counter decrements each cycle; when the counter equals 1, the next state is RESP.
- In RESP, `resp_valid=1` for exactly one cycle. A request accepted in that same cycle re-enters the pipeline; otherwise the FSM returns to IDLE.
- Word index = `((addr - BASE_ADDR) >> 2) mod DEPTH_WORDS`. Out-of-range addresses wrap.
- Store byte lanes:
  - MT_B writes lane `addr[1:0]` from `data[7:0]`.
  - MT_H writes lanes `{addr[1],0}` and `{addr[1],1}` from `data[15:0]`.
  - MT_W writes all four lanes.
  - Other types write nothing.
- Load formatting:
  - MT_B / MT_BU select byte `addr[1:0]`, then sign-extend / zero-extend.
  - MT_H / MT_HU select halfword `addr[1]`, then sign-extend / zero-extend.
  - MT_W returns the whole word.
- The imem port always performs word reads, with `addr[1:0]` ignored.
- Simultaneous dmem store and imem fetch to the same word on the same edge: the fetch returns the old data (read-before-write).
- Memory contents are not reset.
- Reset mid-operation: any in-flight response is discarded, and stores already committed persist.

## Timing
- Reset values: both FSMs in IDLE, `*_resp_valid=0`, `*_resp_data=0`, `*_req_ready=0` while `rst` is high and 1 after release.
- Latency: a request accepted at edge T produces `resp_valid` high during the cycle following edge T+LATENCY-1, i.e. exactly LATENCY cycles later.
- Throughput: one request per LATENCY cycles per port. With `LATENCY=1`, `req_ready` is constantly high and back-to-back requests are supported.
- `resp_data` holds its value after `resp_valid` falls, until the next response.
- The two ports never stall each other.

## Configuration
- `SCRATCHPAD_ALIGN_CHECK_EN` defined:
  - Adds outputs `imem_resp_xcpt` and `dmem_resp_xcpt` (1 bit each, reset 0), valid alongside `resp_valid`.
  - A fetch with `addr[1:0]!=0`, an MT_H/MT_HU access with `addr[0]=1`, or an MT_W access with `addr[1:0]!=0` sets `xcpt=1` and `resp_data=0`, and the store is suppressed.
- Undefined: no `xcpt` ports. Misaligned low address bits are ignored as described under Operation, and no access is suppressed.

## Test plan
- `LATENCY=1`: dmem MT_W store 32'hDEADBEEF to 0x100, then MT_W load from 0x100 -> `resp_valid` one cycle after each accept; the load returns 32'hDEADBEEF.
- MT_B store 8'h80 to 0x103, then MT_B load -> 32'hFFFFFF80; MT_BU load -> 32'h00000080; MT_W load -> 32'h80ADBEEF.
- `LATENCY=3`: imem fetches held valid continuously -> `req_ready` pattern 1,0,0 repeating, with a response every 3rd cycle.
- Same edge: dmem MT_W store 32'h1 to 0x40 and imem fetch of 0x40 (old value 0) -> imem returns 0; a subsequent fetch returns 1.
- Address wrap: store to `BASE_ADDR + 4*DEPTH_WORDS`, then load from `BASE_ADDR` -> returns the stored value.
- `rst` pulsed while a `LATENCY=3` load is in BUSY -> no `resp_valid`, `req_ready` low during reset and high after; a new load is served normally.

Source files
------------

// File: rtl/scratchpad_mem.sv
// scratchpad_mem: dual-port scratchpad responder for the core's instruction-fetch
// (imem) and data (dmem) ports. Each port accepts one request at a time over
// valid/ready and answers exactly LATENCY cycles after acceptance.
// Optional feature macro: SCRATCHPAD_ALIGN_CHECK_EN adds misalignment exception
// outputs (imem_resp_xcpt, dmem_resp_xcpt) and suppresses misaligned accesses.
module scratchpad_mem #(
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_req_valid,
  output logic        imem_req_ready,
  input  logic [31:0] imem_req_addr,
  output logic        imem_resp_valid,
  output logic [31:0] imem_resp_data,
  input  logic        dmem_req_valid,
  output logic        dmem_req_ready,
  input  logic [31:0] dmem_req_addr,
  input  logic [31:0] dmem_req_data,
  input  logic        dmem_req_fcn,
  input  logic [2:0]  dmem_req_typ,
  output logic        dmem_resp_valid,
  output logic [31:0] dmem_resp_data
`ifdef SCRATCHPAD_ALIGN_CHECK_EN
  ,
  output logic        imem_resp_xcpt,
  output logic        dmem_resp_xcpt
`endif
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [1:0]  CNT_INIT = 2'(LATENCY - 1);

  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  logic [31:0] mem [DEPTH_WORDS];

  state_e      iState_q, dState_q;
  logic [1:0]  iCnt_q, dCnt_q;
  logic [31:0] iWord_q, dWord_q;
  logic        iMis_q, dMis_q;
  logic [2:0]  dTyp_q;
  logic        dFcn_q;
  logic [1:0]  dOff_q;
  logic        iRespValid_q, dRespValid_q;
  logic [31:0] iRespData_q, dRespData_q;
  logic        iXcpt_q, dXcpt_q;

  logic [31:0]   iRel, dRel;
  logic [AW-1:0] iIdx, dIdx;
  logic          iAccept, dAccept;
  logic          iMis, dMis;
  logic [3:0]    dBe;
  logic [31:0]   dWdata;
  logic          unusedBits;

  assign iRel    = imem_req_addr - BASE_ADDR;
  assign dRel    = dmem_req_addr - BASE_ADDR;
  assign iIdx    = iRel[AW+1:2];
  assign dIdx    = dRel[AW+1:2];

  assign imem_req_ready = !rst && (iState_q != BUSY);
  assign dmem_req_ready = !rst && (dState_q != BUSY);
  assign iAccept        = imem_req_valid && imem_req_ready;
  assign dAccept        = dmem_req_valid && dmem_req_ready;

  assign imem_resp_valid = iRespValid_q;
  assign imem_resp_data  = iRespData_q;
  assign dmem_resp_valid = dRespValid_q;
  assign dmem_resp_data  = dRespData_q;

`ifdef SCRATCHPAD_ALIGN_CHECK_EN
  assign iMis = (imem_req_addr[1:0] != 2'b00);
  assign dMis = (((dmem_req_typ == MT_H) || (dmem_req_typ == MT_HU)) && dmem_req_addr[0]) ||
                ((dmem_req_typ == MT_W) && (dmem_req_addr[1:0] != 2'b00));
  assign imem_resp_xcpt = iXcpt_q;
  assign dmem_resp_xcpt = dXcpt_q;
`else
  assign iMis = 1'b0;
  assign dMis = 1'b0;
`endif

  // Word-index bits above the memory size and the byte offsets are deliberately dropped.
  assign unusedBits = ^{iRel[31:AW+2], iRel[1:0], dRel[31:AW+2], dRel[1:0],
                        imem_req_addr[1:0], iXcpt_q, dXcpt_q};

  // Select and extend the addressed byte/halfword of a word; stores and faults return 0.
  function automatic logic [31:0] fmtLoad(input logic [31:0] w, input logic [2:0] typ,
                                          input logic [1:0] off, input logic fcn,
                                          input logic mis);
    logic [31:0] sh;
    logic [15:0] h;
    sh = w >> {off, 3'b000};
    h  = off[1] ? w[31:16] : w[15:0];
    fmtLoad = 32'h0;
    if (!fcn && !mis) begin
      case (typ)
        MT_B:    fmtLoad = {{24{sh[7]}}, sh[7:0]};
        MT_BU:   fmtLoad = {24'h0, sh[7:0]};
        MT_H:    fmtLoad = {{16{h[15]}}, h};
        MT_HU:   fmtLoad = {16'h0, h};
        MT_W:    fmtLoad = w;
        default: fmtLoad = 32'h0;
      endcase
    end
  endfunction

  // Store lane enables and lane-replicated store data from type and byte offset.
  always_comb begin
    dBe    = 4'b0000;
    dWdata = dmem_req_data;
    case (dmem_req_typ)
      MT_B: begin
        dBe    = 4'b0001 << dmem_req_addr[1:0];
        dWdata = {4{dmem_req_data[7:0]}};
      end
      MT_H: begin
        dBe    = dmem_req_addr[1] ? 4'b1100 : 4'b0011;
        dWdata = {2{dmem_req_data[15:0]}};
      end
      MT_W:    dBe = 4'b1111;
      default: dBe = 4'b0000;
    endcase
  end

  // Commit stores on acceptance; contents survive reset, and same-edge fetches see the old word.
  always_ff @(posedge clk) begin
    if (dAccept && dmem_req_fcn && !dMis) begin
      for (int b = 0; b < 4; b++) begin
        if (dBe[b]) mem[dIdx][8*b +: 8] <= dWdata[8*b +: 8];
      end
    end
  end

  // Fetch port FSM: capture the word on acceptance, count down, present it for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iState_q     <= IDLE;
      iCnt_q       <= 2'd0;
      iWord_q      <= 32'h0;
      iMis_q       <= 1'b0;
      iRespValid_q <= 1'b0;
      iRespData_q  <= 32'h0;
      iXcpt_q      <= 1'b0;
    end else begin
      iRespValid_q <= 1'b0;
      case (iState_q)
        BUSY: begin
          iCnt_q <= iCnt_q - 2'd1;
          if (iCnt_q == 2'd1) begin
            iState_q     <= RESP;
            iRespValid_q <= 1'b1;
            iRespData_q  <= iMis_q ? 32'h0 : iWord_q;
            iXcpt_q      <= iMis_q;
          end
        end
        default: begin
          if (iAccept) begin
            iMis_q  <= iMis;
            iWord_q <= mem[iIdx];
            if (LATENCY == 1) begin
              iState_q     <= RESP;
              iRespValid_q <= 1'b1;
              iRespData_q  <= iMis ? 32'h0 : mem[iIdx];
              iXcpt_q      <= iMis;
            end else begin
              iState_q <= BUSY;
              iCnt_q   <= CNT_INIT;
            end
          end else begin
            iState_q <= IDLE;
          end
        end
      endcase
    end
  end

  // Data port FSM: latch access attributes and word on acceptance, format on response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dState_q     <= IDLE;
      dCnt_q       <= 2'd0;
      dWord_q      <= 32'h0;
      dMis_q       <= 1'b0;
      dTyp_q       <= 3'd0;
      dFcn_q       <= 1'b0;
      dOff_q       <= 2'd0;
      dRespValid_q <= 1'b0;
      dRespData_q  <= 32'h0;
      dXcpt_q      <= 1'b0;
    end else begin
      dRespValid_q <= 1'b0;
      case (dState_q)
        BUSY: begin
          dCnt_q <= dCnt_q - 2'd1;
          if (dCnt_q == 2'd1) begin
            dState_q     <= RESP;
            dRespValid_q <= 1'b1;
            dRespData_q  <= fmtLoad(dWord_q, dTyp_q, dOff_q, dFcn_q, dMis_q);
            dXcpt_q      <= dMis_q;
          end
        end
        default: begin
          if (dAccept) begin
            dMis_q  <= dMis;
            dTyp_q  <= dmem_req_typ;
            dFcn_q  <= dmem_req_fcn;
            dOff_q  <= dmem_req_addr[1:0];
            dWord_q <= mem[dIdx];
            if (LATENCY == 1) begin
              dState_q     <= RESP;
              dRespValid_q <= 1'b1;
              dRespData_q  <= fmtLoad(mem[dIdx], dmem_req_typ, dmem_req_addr[1:0],
                                      dmem_req_fcn, dMis);
              dXcpt_q      <= dMis;
            end else begin
              dState_q <= BUSY;
              dCnt_q   <= CNT_INIT;
            end
          end else begin
            dState_q <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scratchpad_mem.sv
// Testbench for scratchpad_mem: one LATENCY=1 instance and one LATENCY=3 instance.
module tb_scratchpad_mem;

  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;
  localparam logic       LD    = 1'b0;
  localparam logic       ST    = 1'b1;

  logic clk = 1'b0;
  logic rst1, rst3;

  logic        i1Valid, i1Ready, i1RespValid;
  logic [31:0] i1Addr, i1RespData;
  logic        d1Valid, d1Ready, d1Fcn, d1RespValid;
  logic [2:0]  d1Typ;
  logic [31:0] d1Addr, d1Wdata, d1RespData;

  logic        i3Valid, i3Ready, i3RespValid;
  logic [31:0] i3Addr, i3RespData;
  logic        d3Valid, d3Ready, d3Fcn, d3RespValid;
  logic [2:0]  d3Typ;
  logic [31:0] d3Addr, d3Wdata, d3RespData;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic        fcn;
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs [$];

  always #5 clk = ~clk;

  scratchpad_mem #(.DEPTH_WORDS(16384), .LATENCY(1), .BASE_ADDR(32'h0)) dut1 (
    .clk(clk), .rst(rst1),
    .imem_req_valid(i1Valid), .imem_req_ready(i1Ready), .imem_req_addr(i1Addr),
    .imem_resp_valid(i1RespValid), .imem_resp_data(i1RespData),
    .dmem_req_valid(d1Valid), .dmem_req_ready(d1Ready), .dmem_req_addr(d1Addr),
    .dmem_req_data(d1Wdata), .dmem_req_fcn(d1Fcn), .dmem_req_typ(d1Typ),
    .dmem_resp_valid(d1RespValid), .dmem_resp_data(d1RespData)
  );

  scratchpad_mem #(.DEPTH_WORDS(1024), .LATENCY(3), .BASE_ADDR(32'h0)) dut3 (
    .clk(clk), .rst(rst3),
    .imem_req_valid(i3Valid), .imem_req_ready(i3Ready), .imem_req_addr(i3Addr),
    .imem_resp_valid(i3RespValid), .imem_resp_data(i3RespData),
    .dmem_req_valid(d3Valid), .dmem_req_ready(d3Ready), .dmem_req_addr(d3Addr),
    .dmem_req_data(d3Wdata), .dmem_req_fcn(d3Fcn), .dmem_req_typ(d3Typ),
    .dmem_resp_valid(d3RespValid), .dmem_resp_data(d3RespData)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expVal);
    testsRun++;
    if (act !== expVal) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expVal);
    end
  endtask

  // One dmem transaction; called and returns just after a rising edge (+1).
  task automatic applyStimulus(input bit sel3, input logic fcn, input logic [2:0] typ,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output int lat);
    int guard;
    guard = 0;
    while (!(sel3 ? d3Ready : d1Ready) && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    if (sel3) begin
      d3Valid = 1'b1; d3Fcn = fcn; d3Typ = typ; d3Addr = addr; d3Wdata = wdata;
    end else begin
      d1Valid = 1'b1; d1Fcn = fcn; d1Typ = typ; d1Addr = addr; d1Wdata = wdata;
    end
    @(posedge clk); #1;
    d1Valid = 1'b0;
    d3Valid = 1'b0;
    lat   = -1;
    rdata = 32'h0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      if (sel3 ? d3RespValid : d1RespValid) begin
        lat   = c;
        rdata = sel3 ? d3RespData : d1RespData;
        break;
      end
    end
  endtask

  function automatic void addVec(input logic fcn, input logic [2:0] typ, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] expData);
    vec_t v;
    v.fcn = fcn; v.typ = typ; v.addr = addr; v.wdata = wdata; v.expData = expData;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [31:0] rdata;
    logic [31:0] words3 [3];
    int          lat;
    bit          sawValid;

    addVec(ST, MT_W,  32'h100,   32'hDEADBEEF, 32'h0);
    addVec(LD, MT_W,  32'h100,   32'h0,        32'hDEADBEEF);
    addVec(ST, MT_B,  32'h103,   32'h12345680, 32'h0);
    addVec(LD, MT_B,  32'h103,   32'h0,        32'hFFFFFF80);
    addVec(LD, MT_BU, 32'h103,   32'h0,        32'h00000080);
    addVec(LD, MT_W,  32'h100,   32'h0,        32'h80ADBEEF);
    addVec(ST, MT_H,  32'h102,   32'hABCD1234, 32'h0);
    addVec(LD, MT_HU, 32'h102,   32'h0,        32'h00001234);
    addVec(LD, MT_H,  32'h100,   32'h0,        32'hFFFFBEEF);
    addVec(LD, MT_HU, 32'h100,   32'h0,        32'h0000BEEF);
    addVec(LD, MT_B,  32'h101,   32'h0,        32'hFFFFFFBE);
    addVec(LD, MT_BU, 32'h100,   32'h0,        32'h000000EF);
    addVec(ST, MT_W,  32'h104,   32'h0,        32'h0);
    addVec(ST, MT_H,  32'h106,   32'hABCD8001, 32'h0);
    addVec(LD, MT_H,  32'h106,   32'h0,        32'hFFFF8001);
    addVec(LD, MT_W,  32'h104,   32'h0,        32'h80010000);
    addVec(ST, MT_B,  32'h104,   32'h000000A5, 32'h0);
    addVec(LD, MT_BU, 32'h104,   32'h0,        32'h000000A5);
    addVec(LD, MT_B,  32'h105,   32'h0,        32'h00000000);
    addVec(ST, 3'd4,  32'h100,   32'hFFFFFFFF, 32'h0);
    addVec(LD, MT_W,  32'h100,   32'h0,        32'h1234BEEF);
    addVec(LD, MT_W,  32'h102,   32'h0,        32'h1234BEEF);
    addVec(ST, MT_W,  32'h10000, 32'hCAFEF00D, 32'h0);
    addVec(LD, MT_W,  32'h0,     32'h0,        32'hCAFEF00D);
    addVec(ST, MT_W,  32'h40,    32'h0,        32'h0);

    rst1 = 1'b1; rst3 = 1'b1;
    i1Valid = 1'b0; i1Addr = 32'h0;
    d1Valid = 1'b0; d1Fcn = LD; d1Typ = MT_W; d1Addr = 32'h0; d1Wdata = 32'h0;
    i3Valid = 1'b0; i3Addr = 32'h0;
    d3Valid = 1'b0; d3Fcn = LD; d3Typ = MT_W; d3Addr = 32'h0; d3Wdata = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst i1Ready", {31'b0, i1Ready}, 32'd0);
    checkOutput("rst d1Ready", {31'b0, d1Ready}, 32'd0);
    checkOutput("rst d3Ready", {31'b0, d3Ready}, 32'd0);
    checkOutput("rst d1RespValid", {31'b0, d1RespValid}, 32'd0);
    checkOutput("rst i1RespData", i1RespData, 32'h0);
    checkOutput("rst d1RespData", d1RespData, 32'h0);
    rst1 = 1'b0; rst3 = 1'b0;
    #1;
    checkOutput("post-rst i1Ready", {31'b0, i1Ready}, 32'd1);
    checkOutput("post-rst d1Ready", {31'b0, d1Ready}, 32'd1);
    @(posedge clk); #1;

    // Table-driven dmem vectors on the LATENCY=1 instance
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(1'b0, vecs[i].fcn, vecs[i].typ, vecs[i].addr, vecs[i].wdata, rdata, lat);
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'd1);
      checkOutput($sformatf("vec%0d data", i), rdata, vecs[i].expData);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d pulse", i), {31'b0, d1RespValid}, 32'd0);
      checkOutput($sformatf("vec%0d hold", i), d1RespData, vecs[i].expData);
    end

    // Back-to-back dmem loads at LATENCY=1
    d1Valid = 1'b1; d1Fcn = LD; d1Typ = MT_W; d1Addr = 32'h100;
    @(posedge clk); #1;
    checkOutput("b2b first valid", {31'b0, d1RespValid}, 32'd1);
    checkOutput("b2b first data", d1RespData, 32'h1234BEEF);
    checkOutput("b2b ready", {31'b0, d1Ready}, 32'd1);
    d1Addr = 32'h104;
    @(posedge clk); #1;
    checkOutput("b2b second valid", {31'b0, d1RespValid}, 32'd1);
    checkOutput("b2b second data", d1RespData, 32'h800100A5);
    d1Valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("b2b idle", {31'b0, d1RespValid}, 32'd0);

    // Back-to-back imem fetches at LATENCY=1
    i1Valid = 1'b1; i1Addr = 32'h100;
    @(posedge clk); #1;
    checkOutput("ifetch first", i1RespData, 32'h1234BEEF);
    i1Addr = 32'h0;
    @(posedge clk); #1;
    checkOutput("ifetch second valid", {31'b0, i1RespValid}, 32'd1);
    checkOutput("ifetch second", i1RespData, 32'hCAFEF00D);
    i1Valid = 1'b0;
    @(posedge clk); #1;

    // Same-edge store and fetch to one word: fetch sees the old data
    d1Valid = 1'b1; d1Fcn = ST; d1Typ = MT_W; d1Addr = 32'h40; d1Wdata = 32'h1;
    i1Valid = 1'b1; i1Addr = 32'h40;
    @(posedge clk); #1;
    checkOutput("same-edge fetch valid", {31'b0, i1RespValid}, 32'd1);
    checkOutput("same-edge fetch old", i1RespData, 32'h0);
    checkOutput("same-edge store valid", {31'b0, d1RespValid}, 32'd1);
    d1Valid = 1'b0;
    i1Addr = 32'h42;
    @(posedge clk); #1;
    checkOutput("refetch new", i1RespData, 32'h1);
    i1Valid = 1'b0;
    @(posedge clk); #1;

    // LATENCY=3: preload through dmem and check the latency
    words3[0] = 32'h11111111; words3[1] = 32'h22222222; words3[2] = 32'h33333333;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, ST, MT_W, 32'(4 * i), words3[i], rdata, lat);
      checkOutput($sformatf("lat3 store%0d latency", i), 32'(lat), 32'd3);
    end
    applyStimulus(1'b1, LD, MT_HU, 32'h6, 32'h0, rdata, lat);
    checkOutput("lat3 load latency", 32'(lat), 32'd3);
    checkOutput("lat3 load data", rdata, 32'h00002222);
    @(posedge clk); #1;

    // LATENCY=3 imem held valid: ready 1,0,0 and a response every third cycle
    i3Valid = 1'b1; i3Addr = 32'h0;
    for (int k = 0; k <= 9; k++) begin
      checkOutput($sformatf("lat3 ready k%0d", k), {31'b0, i3Ready}, (k % 3 == 0) ? 32'd1 : 32'd0);
      if (k > 0)
        checkOutput($sformatf("lat3 rvalid k%0d", k), {31'b0, i3RespValid},
                    (k % 3 == 0) ? 32'd1 : 32'd0);
      if (k > 0 && k % 3 == 0)
        checkOutput($sformatf("lat3 rdata k%0d", k), i3RespData, words3[k / 3 - 1]);
      if (k == 9) begin
        i3Valid = 1'b0;
        break;
      end
      @(posedge clk); #1;
      if (k % 3 == 0) i3Addr = 32'(4 * (k / 3 + 1));
    end
    @(posedge clk); #1;
    checkOutput("lat3 ifetch done", {31'b0, i3RespValid}, 32'd0);

    // Reset while a LATENCY=3 load is in BUSY
    d3Valid = 1'b1; d3Fcn = LD; d3Typ = MT_W; d3Addr = 32'h4;
    @(posedge clk); #1;
    d3Valid = 1'b0;
    checkOutput("busy ready", {31'b0, d3Ready}, 32'd0);
    rst3 = 1'b1;
    #1;
    checkOutput("mid-rst ready", {31'b0, d3Ready}, 32'd0);
    checkOutput("mid-rst irespdata", i3RespData, 32'h0);
    @(posedge clk); #1;
    checkOutput("mid-rst ready held", {31'b0, d3Ready}, 32'd0);
    rst3 = 1'b0;
    #1;
    checkOutput("after-rst ready", {31'b0, d3Ready}, 32'd1);
    sawValid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (d3RespValid) sawValid = 1'b1;
    end
    checkOutput("discarded resp", {31'b0, sawValid}, 32'd0);
    applyStimulus(1'b1, LD, MT_W, 32'h4, 32'h0, rdata, lat);
    checkOutput("post-rst load latency", 32'(lat), 32'd3);
    checkOutput("post-rst load data", rdata, 32'h22222222);
    applyStimulus(1'b1, LD, MT_B, 32'h3, 32'h0, rdata, lat);
    checkOutput("persist store", rdata, 32'h00000011);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Global time limit so a stuck DUT can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

endmodule
